// File: rtl/wam_pkg.sv
// Shared definitions for the score display path.
//   - SEG_0..SEG_9, SEG_BLANK: 7-bit segment patterns, bit0 = a ... bit6 = g,
//     1 = segment lit.
//   - state_e: controller FSM states.
//   - ndig_required(): decimal digits needed to show 2^bin_w - 1; the top
//     uses it to reject a BIN_W/NDIG pairing that cannot show every value.
package wam_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int ndig_required(input int bin_w);
        longint unsigned v;
        int              n;
        v = (longint'(1) << bin_w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to seven-segment encoder.
//   digit_i [3:0] : BCD digit; codes 10..15 light nothing
//   blank_i       : 1 forces all segments off
//   seg_o   [6:0] : segments, bit0 = a ... bit6 = g, 1 = lit
module seg7_encode
    import wam_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_hex_ctrl.sv
// Score readout controller: binary value -> NDIG BCD digits (double-dabble,
// one shift per cycle) -> seven-segment outputs with optional leading-zero
// blanking and a global enable.
//   clk, reset         : clock, synchronous active-high reset
//   load, value        : start a conversion of value (accepted only in IDLE)
//   blank_lz           : leading-zero blanking, captured with value
//   en                 : 0 forces hex to all-off, combinationally
//   busy               : conversion in progress
//   done               : one-cycle pulse, new result now on hex
//   hex [7*NDIG-1:0]   : digit i segments at [7i+6:7i]
module score_hex_ctrl
    import wam_pkg::*;
#(
    parameter int BIN_W = 10,
    parameter int NDIG  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    input  logic              blank_lz,
    input  logic              en,
    output logic              busy,
    output logic              done,
    output logic [7*NDIG-1:0] hex
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * NDIG;

    if (NDIG < ndig_required(BIN_W)) begin : g_ndig_too_small
        $error("score_hex_ctrl: NDIG too small to display 2^BIN_W-1");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             lz_q, lz_d;
    logic [BW-1:0]    disp_q, disp_d;
    logic             disp_lz_q, disp_lz_d;
    logic             disp_on_q, disp_on_d;   // 0 until the first result lands
    logic             done_q, done_d;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_shift;
    logic             last_shift;

    // Add-3 correction, each nibble on its own: a 4-bit add of a value <= 9
    // plus 3 never overflows, so no carry can leave the nibble.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                    ? bcd_q[4*gi +: 4] + 4'd3
                                    : bcd_q[4*gi +: 4];
    end

    // Upper half of {bcd, bin} << 1: the binary MSB enters the BCD LSB.
    assign bcd_shift  = (bcd_adj << 1) | BW'(bin_q[BIN_W-1]);
    assign last_shift = (cnt_q == CW'(BIN_W - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        lz_d      = lz_q;
        disp_d    = disp_q;
        disp_lz_d = disp_lz_q;
        disp_on_d = disp_on_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    lz_d    = blank_lz;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (last_shift) begin
                    state_d   = IDLE;
                    disp_d    = bcd_shift;
                    disp_lz_d = lz_q;
                    disp_on_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            lz_q      <= 1'b0;
            disp_q    <= '0;
            disp_lz_q <= 1'b0;
            disp_on_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            lz_q      <= lz_d;
            disp_q    <= disp_d;
            disp_lz_q <= disp_lz_d;
            disp_on_q <= disp_on_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;

    // hi_zero[i]: digit i and every digit above it are zero.
    // hi_zero[NDIG] stands for "nothing above the top digit".
    logic [NDIG:1]     hi_zero;
    logic [NDIG-1:0]   dig_blank;
    logic [7*NDIG-1:0] seg_all;

    assign hi_zero[NDIG] = 1'b1;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            // The units digit always shows once a result exists, so 0 reads "0".
            assign dig_blank[gi] = !disp_on_q;
        end else begin : g_upper
            assign hi_zero[gi]   = (disp_q[4*gi +: 4] == 4'd0) && hi_zero[gi+1];
            assign dig_blank[gi] = !disp_on_q || (disp_lz_q && hi_zero[gi]);
        end

        seg7_encode u_enc (
            .digit_i (disp_q[4*gi +: 4]),
            .blank_i (dig_blank[gi]),
            .seg_o   (seg_all[7*gi +: 7])
        );
    end

    assign hex = en ? seg_all : '0;

endmodule

// File: tb/tb_score_hex_ctrl.sv
module tb_score_hex_ctrl;

    localparam int BIN_W = 10;
    localparam int NDIG  = 4;
    localparam int HW    = 7 * NDIG;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [BIN_W-1:0]  value = '0;
    logic              blank_lz = 1'b0;
    logic              en = 1'b1;
    logic              busy;
    logic              done;
    logic [HW-1:0]     hex;

    score_hex_ctrl #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; a load set up while cyc == N is
    // sampled on edge N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            acc;   // edge on which the load was accepted
        logic [HW-1:0] hex;   // expected display after the conversion
    } ent_t;

    ent_t q[$];
    int   next_free = 0;      // first edge on which a load will be accepted
    int   checks = 0;
    int   errors = 0;

    // Reference display: decimal digits by division, blanking from magnitude.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tab[d];
    endfunction

    function automatic logic [HW-1:0] model_hex(input int v, input bit b);
        logic [HW-1:0] r;
        int            p;
        r = '0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (!(b && i > 0 && v < p))
                r[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v, input bit b);
        value    = BIN_W'(v);
        blank_lz = b;
        load     = 1'b1;
        if (cyc >= next_free) begin
            q.push_back('{acc: cyc, hex: model_hex(v, b)});
            next_free = cyc + BIN_W + 1;
        end
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        next_free = cyc + n;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < next_free) tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    bit            armed = 1'b0;
    logic [HW-1:0] disp_exp = '0;

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy),
                32'(q.size() > 0 && cyc >= q[0].acc + 1 && cyc <= q[0].acc + BIN_W));
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    chk("done_cycle", 32'(cyc), 32'(q[0].acc + BIN_W + 1));
                    disp_exp = q[0].hex;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc > q[0].acc + BIN_W + 1) begin
                chk("missing_done", 32'(done), 32'd1);
                disp_exp = q[0].hex;
                void'(q.pop_front());
            end
            chk("hex", 32'(hex), 32'(en ? disp_exp : '0));
        end
        if (reset) begin
            armed    = 1'b1;
            disp_exp = '0;
            q.delete();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset(3);
        repeat (3) tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;

        do_load(0, 1'b1);
        wait_idle();
        tick();
        do_load(1023, 1'b0);
        wait_idle();
        tick();
        do_load(407, 1'b1);
        wait_idle();
        tick();

        // Second load mid-conversion is ignored; the one in the done cycle is taken.
        do_load(123, 1'b0);
        repeat (3) tick();
        do_load(456, 1'b0);
        wait_idle();
        do_load(456, 1'b0);
        wait_idle();
        tick();

        // Enable gating without a new conversion.
        do_load(88, 1'b1);
        wait_idle();
        tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (2) tick();

        // Reset aborts a conversion and blanks the display.
        do_load(999, 1'b0);
        repeat (4) tick();
        do_reset(1);
        repeat (BIN_W + 3) tick();

        // Randomized loads, gaps and enable.
        for (int n = 0; n < 40; n++) begin
            do_load(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 14)) begin
                en = ($urandom_range(0, 7) != 0);
                tick();
            end
        end
        en = 1'b1;
        repeat (BIN_W + 5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
